// File: rtl/note_tone_gen.sv
// note_tone_gen: plays a 50% duty square wave for note index 0..36 (55 Hz base, semitone steps); optional TONE_FREQ_ECHO_EN adds freq_out.
// Latency: tone starts high the cycle after accept; note changes and stops land on whole-period boundaries.
// Backpressure: note_ready low while stop is high, while stopping, or while a pending note waits for its boundary.
module note_tone_gen #(
    parameter int CLK_HZ      = 100000000,
    parameter int HP_W        = 24,
    parameter int TICK_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [5:0]  note_idx,
    input  logic [15:0] note_dur,
    input  logic        stop,
    output logic        tone_out,
    output logic        busy,
    output logic [3:0]  cur_note,
    output logic [5:0]  cur_idx,
`ifdef TONE_FREQ_ECHO_EN
    output logic [18:0] freq_out,
`endif
    output logic        note_err
);

    localparam int NOTES = 37;
    localparam int PW    = $clog2(TICK_CYCLES + 1);

    typedef logic [63:0] u64_t;

    // Hz x1000, floor(55000 * 2^(i/12))
    function automatic logic [18:0] freq_of(input int i);
        case (i)
            0:  freq_of = 19'd55000;   1:  freq_of = 19'd58270;   2:  freq_of = 19'd61735;
            3:  freq_of = 19'd65406;   4:  freq_of = 19'd69295;   5:  freq_of = 19'd73416;
            6:  freq_of = 19'd77781;   7:  freq_of = 19'd82406;   8:  freq_of = 19'd87307;
            9:  freq_of = 19'd92498;   10: freq_of = 19'd97998;   11: freq_of = 19'd103826;
            12: freq_of = 19'd110000;  13: freq_of = 19'd116540;  14: freq_of = 19'd123470;
            15: freq_of = 19'd130812;  16: freq_of = 19'd138591;  17: freq_of = 19'd146832;
            18: freq_of = 19'd155563;  19: freq_of = 19'd164813;  20: freq_of = 19'd174614;
            21: freq_of = 19'd184997;  22: freq_of = 19'd195997;  23: freq_of = 19'd207652;
            24: freq_of = 19'd220000;  25: freq_of = 19'd233081;  26: freq_of = 19'd246941;
            27: freq_of = 19'd261625;  28: freq_of = 19'd277182;  29: freq_of = 19'd293664;
            30: freq_of = 19'd311126;  31: freq_of = 19'd329627;  32: freq_of = 19'd349228;
            33: freq_of = 19'd369994;  34: freq_of = 19'd391995;  35: freq_of = 19'd415304;
            36: freq_of = 19'd440000;
            default: freq_of = 19'd0;
        endcase
    endfunction

    function automatic u64_t half_of(input int i);
        half_of = (u64_t'(CLK_HZ) * 64'd1000) / (64'd2 * u64_t'(freq_of(i)));
    endfunction

    function automatic logic [NOTES*HP_W-1:0] build_half();
        logic [NOTES*HP_W-1:0] t;
        t = '0;
        for (int i = 0; i < NOTES; i++) t[i*HP_W +: HP_W] = HP_W'(half_of(i));
        return t;
    endfunction

    function automatic bit half_fits();
        half_fits = 1'b1;
        for (int i = 0; i < NOTES; i++)
            if (half_of(i) >= (u64_t'(1) << HP_W)) half_fits = 1'b0;
    endfunction

    localparam logic [NOTES*HP_W-1:0] HALF_PK = build_half();

    if (!half_fits()) begin : g_hp_overflow
        $error("note_tone_gen: half-period table does not fit in HP_W bits");
    end

    function automatic logic [HP_W-1:0] hp_lut(input logic [5:0] i);
        hp_lut = HALF_PK[int'(i)*HP_W +: HP_W];
    endfunction

    function automatic logic [3:0] note_of(input logic [5:0] i);
        note_of = 4'(i % 6'd12);
    endfunction

    typedef enum logic [1:0] {IDLE, PLAY, STOPPING} state_t;

    state_t          state, state_nxt;
    logic [HP_W-1:0] hp, hc, pend_hp, sel_hp;
    logic [PW-1:0]   presc;
    logic [15:0]     dur_cnt, pend_dur, sel_dur;
    logic [5:0]      pend_idx, sel_idx;
    logic            dur_en, pend_vld;
    logic            accept, idx_ok, hc_wrap, bnd, tick, expire;
    logic            load_new, apply_pend, drop_pend;

    assign idx_ok  = (note_idx <= 6'd36);
    assign hc_wrap = (hc == hp - 1'b1);
    assign bnd     = (state != IDLE) && hc_wrap && !tone_out;
    assign tick    = (presc == PW'(TICK_CYCLES - 1));
    assign expire  = dur_en && tick && (dur_cnt == 16'd1);
    assign busy    = (state != IDLE);

    assign sel_idx = apply_pend ? pend_idx : note_idx;
    assign sel_hp  = apply_pend ? pend_hp  : hp_lut(note_idx);
    assign sel_dur = apply_pend ? pend_dur : note_dur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // An end request on the boundary itself closes playback there, so no extra period.
    always_comb begin
        state_nxt  = state;
        load_new   = 1'b0;
        apply_pend = 1'b0;
        drop_pend  = 1'b0;
        note_ready = !stop && (state == IDLE || (state == PLAY && !pend_vld));
        accept     = note_valid && note_ready;
        case (state)
            IDLE: begin
                if (accept && idx_ok) begin
                    state_nxt = PLAY;
                    load_new  = 1'b1;
                end
            end
            PLAY: begin
                if (bnd) begin
                    if (stop || expire) begin
                        state_nxt = IDLE;
                        drop_pend = 1'b1;
                    end else if (pend_vld) begin
                        apply_pend = 1'b1;
                    end
                end else if (stop || expire) begin
                    state_nxt = STOPPING;
                    drop_pend = 1'b1;
                end
            end
            STOPPING: begin
                if (bnd) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_out <= 1'b0;
            cur_note <= '0;
            cur_idx  <= '0;
            note_err <= 1'b0;
            hp       <= '0;
            hc       <= '0;
            presc    <= '0;
            dur_cnt  <= '0;
            dur_en   <= 1'b0;
        end else begin
            note_err <= accept && !idx_ok;
            if (load_new || apply_pend) begin
                hp       <= sel_hp;
                cur_idx  <= sel_idx;
                cur_note <= note_of(sel_idx);
                dur_cnt  <= sel_dur;
                dur_en   <= (sel_dur != 16'd0);
                presc    <= '0;
                hc       <= '0;
                tone_out <= 1'b1;
            end else if (state != IDLE) begin
                hc    <= hc_wrap ? '0 : hc + 1'b1;
                presc <= tick ? '0 : presc + 1'b1;
                if (hc_wrap) tone_out <= ~tone_out && (state_nxt != IDLE);
                if (tick && dur_cnt != 16'd0) dur_cnt <= dur_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend_idx <= '0;
            pend_hp  <= '0;
            pend_dur <= '0;
        end else if (drop_pend || apply_pend) begin
            pend_vld <= 1'b0;
        end else if (accept && idx_ok && state == PLAY) begin
            pend_vld <= 1'b1;
            pend_idx <= note_idx;
            pend_hp  <= hp_lut(note_idx);
            pend_dur <= note_dur;
        end
    end

`ifdef TONE_FREQ_ECHO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       freq_out <= '0;
        else if (load_new || apply_pend)  freq_out <= freq_of(int'(sel_idx));
    end
`endif

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: vector table, hand-written boundary sequences, and random notes against a frequency/period model.
module tb_note_tone_gen;
    localparam int CLK_HZ = 110000;
    localparam int TICK   = 100;
    localparam int HP_W   = 24;

    logic        clk = 1'b0, rst_n = 1'b0, note_valid = 1'b0, stop = 1'b0;
    logic [5:0]  note_idx = '0;
    logic [15:0] note_dur = '0;
    logic        note_ready, tone_out, busy, note_err;
    logic [3:0]  cur_note;
    logic [5:0]  cur_idx;
`ifdef TONE_FREQ_ECHO_EN
    logic [18:0] freq_out;
`endif

    int n_cmp = 0, n_bad = 0;
    int runs[$];

    always #5 clk = ~clk;

    note_tone_gen #(.CLK_HZ(CLK_HZ), .HP_W(HP_W), .TICK_CYCLES(TICK)) dut (
        .clk(clk), .rst_n(rst_n), .note_valid(note_valid), .note_ready(note_ready),
        .note_idx(note_idx), .note_dur(note_dur), .stop(stop), .tone_out(tone_out),
        .busy(busy), .cur_note(cur_note), .cur_idx(cur_idx),
`ifdef TONE_FREQ_ECHO_EN
        .freq_out(freq_out),
`endif
        .note_err(note_err)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
        end
    endtask

    function automatic longint model_freq(input int i);
        real f;
        f = $floor(55000.0 * (2.0 ** (real'(i) / 12.0)));
        return longint'(f);
    endfunction

    function automatic longint model_half(input int i);
        return (longint'(CLK_HZ) * 1000) / (2 * model_freq(i));
    endfunction

    // Playback ends at the first period boundary at or after dur*TICK cycles.
    function automatic longint model_periods(input int i, input int dur);
        longint e, p;
        e = longint'(dur) * TICK;
        p = 2 * model_half(i);
        return (e + p - 1) / p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_note(input int idx, input int dur);
        int w;
        w = 0;
        note_idx = 6'(idx);
        note_dur = 16'(dur);
        note_valid = 1'b1;
        #1;
        while (!note_ready && w < 5000) begin
            step();
            w++;
        end
        check("send_ready", note_ready, 1);
        step();
        note_valid = 1'b0;
    endtask

    task automatic count_level(input logic lvl, input int budget, output int n);
        n = 0;
        while (busy && tone_out == lvl && n < budget) begin
            n++;
            step();
        end
    endtask

    task automatic wait_idle(input int budget);
        int w;
        w = 0;
        while (busy && w < budget) begin
            step();
            w++;
        end
        check("wait_idle", busy, 0);
    endtask

    task automatic measure(input int budget);
        int len, cyc;
        logic cur;
        runs.delete();
        len = 0;
        cyc = 0;
        cur = tone_out;
        while (busy && cyc < budget) begin
            if (tone_out == cur) len++;
            else begin
                runs.push_back(len);
                cur = tone_out;
                len = 1;
            end
            cyc++;
            step();
        end
        runs.push_back(len);
        check("measure_ends_idle", busy, 0);
    endtask

    task automatic play_and_check(input string tag, input int idx, input int dur,
                                  input longint hp, input longint periods, input int note);
        int bad;
        send_note(idx, dur);
        check({tag, "_tone_start"}, tone_out, 1);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_cur_idx"}, cur_idx, idx);
        check({tag, "_cur_note"}, cur_note, note);
`ifdef TONE_FREQ_ECHO_EN
        check({tag, "_freq_out"}, freq_out, model_freq(idx));
`endif
        measure(20000);
        check({tag, "_phases"}, runs.size(), 2 * periods);
        bad = 0;
        foreach (runs[k]) if (runs[k] != hp) bad++;
        check({tag, "_phase_len_bad"}, bad, 0);
        check({tag, "_idle_tone"}, tone_out, 0);
        check({tag, "_idle_ready"}, note_ready, 1);
    endtask

    typedef struct {
        int idx;
        int dur;
        int hp;
        int periods;
        int note;
        bit err;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int n, n2, prev_idx;

        vecs = '{
            '{36, 10, 125,  4, 0, 1'b0},
            '{12,  3, 500,  1, 0, 1'b0},
            '{ 0, 20, 1000, 1, 0, 1'b0},
            '{24,  5, 250,  1, 0, 1'b0},
            '{33,  4, 148,  2, 9, 1'b0},
            '{ 7,  2, 667,  1, 7, 1'b0},
            '{40,  5,   0,  0, 0, 1'b1},
            '{63,  0,   0,  0, 0, 1'b1}
        };

        // Reset state
        step(); step();
        check("rst_tone", tone_out, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_note", cur_note, 0);
        check("rst_cur_idx", cur_idx, 0);
        check("rst_note_err", note_err, 0);
`ifdef TONE_FREQ_ECHO_EN
        check("rst_freq_out", freq_out, 0);
`endif
        rst_n = 1'b1;
        step();
        check("rst_ready", note_ready, 1);

        // stop while idle does nothing
        stop = 1'b1;
        step(); step();
        check("stop_idle_busy", busy, 0);
        check("stop_idle_ready", note_ready, 0);
        stop = 1'b0;
        step();

        // Table of single notes
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].err) begin
                prev_idx = int'(cur_idx);
                send_note(vecs[v].idx, vecs[v].dur);
                check($sformatf("vec%0d_err_pulse", v), note_err, 1);
                check($sformatf("vec%0d_err_busy", v), busy, 0);
                check($sformatf("vec%0d_err_tone", v), tone_out, 0);
                check($sformatf("vec%0d_err_idx", v), cur_idx, prev_idx);
                step();
                check($sformatf("vec%0d_err_clear", v), note_err, 0);
            end else begin
                play_and_check($sformatf("vec%0d", v), vecs[v].idx, vecs[v].dur,
                               vecs[v].hp, vecs[v].periods, vecs[v].note);
            end
        end

        // Free-running idx 0, then stop 300 cycles into a high phase with a colliding request
        send_note(0, 0);
        count_level(1'b1, 5000, n);
        check("free_high", n, 1000);
        count_level(1'b0, 5000, n);
        check("free_low", n, 1000);
        check("free_busy", busy, 1);
        check("free_note", cur_note, 0);
        count_level(1'b1, 299, n);
        stop = 1'b1;
        note_valid = 1'b1;
        note_idx = 6'd5;
        note_dur = 16'd0;
        #1;
        check("stop_valid_ready", note_ready, 0);
        step();
        stop = 1'b0;
        note_valid = 1'b0;
        count_level(1'b1, 5000, n);
        check("stop_rest_high", n, 700);
        count_level(1'b0, 5000, n);
        check("stop_low", n, 1000);
        check("stop_busy", busy, 0);
        check("stop_tone", tone_out, 0);
        check("stop_no_accept", cur_idx, 0);

        // Pending note change on the period boundary
        send_note(12, 0);
        count_level(1'b1, 199, n);
        note_idx = 6'd24;
        note_dur = 16'd0;
        note_valid = 1'b1;
        #1;
        check("pend_accept_ready", note_ready, 1);
        step();
        note_valid = 1'b0;
        #1;
        check("pend_ready_low", note_ready, 0);
        check("pend_old_idx", cur_idx, 12);
        count_level(1'b1, 5000, n2);
        check("pend_old_high", n + 1 + n2, 500);
        count_level(1'b0, 5000, n);
        check("pend_old_low", n, 500);
        check("pend_new_idx", cur_idx, 24);
        check("pend_new_note", cur_note, 0);
        check("pend_ready_back", note_ready, 1);
        count_level(1'b1, 5000, n);
        check("pend_new_high", n, 250);
        count_level(1'b0, 5000, n);
        check("pend_new_low", n, 250);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle(5000);

        // Reset in the middle of a high phase
        send_note(0, 0);
        repeat (50) step();
        check("mid_rst_pre_tone", tone_out, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tone_async", tone_out, 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", note_ready, 1);
        check("mid_rst_idx", cur_idx, 0);
`ifdef TONE_FREQ_ECHO_EN
        check("mid_rst_freq", freq_out, 0);
`endif
        send_note(36, 0);
        check("post_rst_idx", cur_idx, 36);
`ifdef TONE_FREQ_ECHO_EN
        check("post_rst_freq", freq_out, 440000);
`endif
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle(5000);

        // Random notes against the model
        for (int t = 0; t < 12; t++) begin
            int ridx, rdur;
            ridx = int'($urandom_range(36, 0));
            rdur = int'($urandom_range(8, 1));
            play_and_check($sformatf("rnd%0d_i%0d_d%0d", t, ridx, rdur), ridx, rdur,
                           model_half(ridx), model_periods(ridx, rdur), ridx % 12);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Inverse of the tuner path: takes a note index (0..36, three octaves from 55 Hz) and generates a 50% duty square wave at that note's frequency.
- Drives the audio output or a test loopback into the tuner. Uses the same frequency table format as the tuner: Hz x1000, 19 bits.
- Notes arrive over a valid/ready handshake and play for a programmable duration or until stopped.
- Note changes and stops take effect only on whole-period boundaries, so no runt pulses are produced.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- HP_W, 24, width of the half-period counter.
- TICK_CYCLES, 100000, clock cycles per duration unit.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- note_valid  in  1  note request valid.
- note_ready  out  1  request accepted when note_valid && note_ready.
- note_idx  in  6  note index; 0 = 55 Hz, each step = one semitone.
- note_dur  in  16  duration in TICK_CYCLES units; 0 = play until stop.
- stop  in  1  level; end playback at the next period boundary.
- tone_out  out  1  square wave.
- busy  out  1  state != IDLE.
- cur_note  out  4  note name of the playing index (idx % 12).
- cur_idx  out  6  playing index.
- note_err  out  1  one-cycle pulse when an accepted index is > 36.

Behaviour:
- Reset (async, active-low): tone_out=0, busy=0, cur_note=0, cur_idx=0, note_err=0, pending cleared, counters 0, state IDLE. note_ready=1 once reset is released.
- Tables (elaboration constants):
  - FREQ[i] = floor(55000 * 2^(i/12)).
  - HALF[i] = floor(CLK_HZ*1000 / (2*FREQ[i])); compute with 64-bit arithmetic.
  - Elaboration fails if any HALF[i] >= 2^HP_W.
- note_ready (combinational) = !stop && (state==IDLE || (state==PLAY && !pend_vld)).
- Invalid index: an accepted handshake with note_idx > 36 pulses note_err the next cycle. State, pending and outputs are otherwise unchanged.
- States:
  - IDLE:
    - tone_out=0.
    - A valid accept loads hp=HALF[idx], cur_idx/cur_note, and the duration counter (note_dur, with the prescaler cleared).
    - Next cycle: state=PLAY, tone_out=1, half counter=0.
  - PLAY:
    - Half counter increments each cycle. At hp-1 it resets to 0 and tone_out toggles, giving hp cycles high and hp cycles low.
    - A period boundary is the cycle where tone_out goes 0->1.
    - An accept in PLAY stores the note in a pending register (note_ready drops). At the next boundary the pending note's hp, cur_idx and duration are applied; its first high phase starts in that same cycle.
  - STOPPING:
    - Entered from PLAY when stop=1 or the duration counter expires. Pending note is discarded.
    - Waveform continues; at the next boundary the 0->1 toggle is suppressed and state goes to IDLE.
- Duration:
  - Prescaler counts TICK_CYCLES; the duration counter decrements once per tick.
  - The counter expires on reaching 0 when note_dur != 0.
  - Expiry in the same cycle as a boundary: go straight to IDLE at that boundary, with no extra period.
  - Expiry or stop in the same cycle as a pending apply: stop wins.
- Simultaneous events:
  - stop and note_valid together: not accepted, because note_ready=0.
  - stop while IDLE: no effect.
- Reset mid-tone: tone_out goes 0 immediately (asynchronous); the pending note is lost.

Optional Feature:
- Macro: TONE_FREQ_ECHO_EN.
- Defined: adds output port freq_out [18:0] = FREQ[cur_idx], registered and updated in the same cycle as cur_idx, reset 0. This is used to check tuner loopback.
- Undefined: no port and no table storage for FREQ beyond what elaboration needs.

Test Plan:
- CLK_HZ=110000, TICK_CYCLES=100; note_idx=0, dur=0 -> tone_out high 1000 cycles, low 1000 cycles, repeating; busy=1, cur_note=0.
- Playing idx 12 (hp=500); send idx 24 mid-high phase -> note_ready=0 until the next boundary, then hp=250, cur_idx=24, cur_note=0; the high phase that finished before the boundary lasted exactly 500 cycles.
- idx 36, dur=10 -> exactly 4 periods of 250 cycles (125 high / 125 low), then IDLE with tone_out=0; total 1000 cycles.
- note_idx=40 accepted in IDLE -> note_err high for exactly 1 cycle, busy stays 0, tone_out stays 0.
- idx 0 playing; stop asserted 300 cycles into the high phase -> 700 more cycles high, 1000 low, then IDLE; stop+valid in the same cycle -> no accept.
- rst_n low for 3 cycles mid high phase -> tone_out=0 asynchronously; after release, busy=0 and note_ready=1; with TONE_FREQ_ECHO_EN, freq_out=0 and then 440000 after idx 36 is accepted.
